// File: rtl/br_alu_mem_core.sv
// Register file + 8-op ALU + data memory behind one valid/ready command port.
// A three-state FSM sequences operand latch, execute or iterative divide, and write-back.
module br_alu_mem_core #(
    parameter  int WIDTH     = 32,
    parameter  int REGS      = 32,
    parameter  int MEM_DEPTH = 32,
    localparam int RA_W      = $clog2(REGS),
    localparam int MA_W      = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [RA_W-1:0]  ra1,
    input  logic [RA_W-1:0]  ra2,
    input  logic [RA_W-1:0]  wa,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic [MA_W-1:0]  mem_addr,
    input  logic             load_en,
    input  logic [RA_W-1:0]  load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [MA_W-1:0]  mem_raddr,
    output logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zf
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             state_q;
    logic               ready_q, out_valid_q, zf_q;
    logic [WIDTH-1:0]   result_q, mem_rdata_q;
    logic [2:0]         sel_q;
    logic [RA_W-1:0]    wa_q;
    logic               rw_q, mw_q;
    logic [MA_W-1:0]    maddr_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic [WIDTH-1:0]   rem_q, quo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   regs_q [REGS];
    logic [WIDTH-1:0]   mem_q  [MEM_DEPTH];

    logic [WIDTH-1:0]   rd1_d, rd2_d, alu_d, rem_d, quo_d, res_d;
    logic [WIDTH:0]     trial_d;
    logic               wb_d;

    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'b111:  r = a + b;
            3'b110:  r = a - b;
            3'b100:  r = a * b;
            3'b001:  r = a & b;
            3'b010:  r = a | b;
            3'b011:  r = a ^ b;
            3'b101:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Operand read, ALU evaluation, restoring-divider step and write-back strobe
    always_comb begin
        rd1_d   = (ra1 == '0) ? '0 : regs_q[ra1];
        rd2_d   = (ra2 == '0) ? '0 : regs_q[ra2];
        alu_d   = alu_f(sel_q, opa_q, opb_q);
        // A zero divisor always leaves trial non-negative, giving an all-ones quotient.
        trial_d = {rem_q, quo_q[WIDTH-1]} - {1'b0, opb_q};
        if (!trial_d[WIDTH]) begin
            rem_d = trial_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (state_q == ST_DIV) begin
            res_d = quo_d;
            wb_d  = (cnt_q == CNT_LAST);
        end else begin
            res_d = alu_d;
            wb_d  = (state_q == ST_EXEC);
        end
    end

    // Control FSM with latched command, divider state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zf_q        <= 1'b0;
            sel_q       <= 3'b000;
            wa_q        <= '0;
            rw_q        <= 1'b0;
            mw_q        <= 1'b0;
            maddr_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sel_q   <= sel;
                        wa_q    <= wa;
                        rw_q    <= reg_write;
                        mw_q    <= mem_write;
                        maddr_q <= mem_addr;
                        opa_q   <= rd1_d;
                        opb_q   <= rd2_d;
                        quo_q   <= rd1_d;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= (sel == 3'b000) ? ST_DIV : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= res_d;
                    zf_q        <= (res_d == '0);
                    out_valid_q <= 1'b1;
                    ready_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (wb_d) begin
                        result_q    <= res_d;
                        zf_q        <= (res_d == '0);
                        out_valid_q <= 1'b1;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file: external load first so a same-edge command write-back overrides it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
        end else begin
            if (load_en && (load_addr != '0)) regs_q[load_addr] <= load_data;
            if (wb_d && rw_q && (wa_q != '0)) regs_q[wa_q] <= res_d;
        end
    end

    // Data memory with registered read port (read-before-write on a shared address)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
            mem_rdata_q <= '0;
        end else begin
            mem_rdata_q <= mem_q[mem_raddr];
            if (wb_d && mw_q) mem_q[maddr_q] <= res_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zf        = zf_q;
    assign mem_rdata = mem_rdata_q;

endmodule
